nisc_seq: RTL and testbench
===========================

Name: nisc_seq

Overview:
Control-word sequencer for the picoNISC datapath; sits directly upstream of the 2-entry register file.
- Fetches horizontal control words from an external synchronous-read program ROM.
- Decodes each word into register-file controls (w, Raddr, Wdata) plus an ALU op.
- Updates its PC sequentially, by unconditional jump, or by branch-on-zero.
- The register-file write data comes from a mux of the immediate, the ALU result and the input port.

Parameters:
n, 8, datapath width (matches register-file n)
Rsize, 1, register address width (matches register-file Rsize)
PCW, 8, program counter width; PCW <= n is required
CWW, n+7+Rsize, control word width (derived; 16 at defaults)

Ports:
clk  input  1  system clock, rising edge
nReset  input  1  asynchronous active-low reset
start  input  1  begin or restart execution (level-sampled in IDLE/HALT)
stall  input  1  hold the current control word in EXEC
pm_addr  output  PCW  program ROM address
pm_data  input  CWW  program ROM data, valid one cycle after pm_addr
z  input  1  zero flag from ALU, sampled in EXEC
alu_res  input  n  ALU result
in_port  input  n  external input data
w  output  1  register-file write enable
Raddr  output  Rsize  register-file address
Wdata  output  n  register-file write data
alu_op  output  2  ALU operation select
halted  output  1  high in HALT state
pc  output  PCW  current program counter

Behaviour:
- Control word fields, MSB first:
  - seq[CWW-1:CWW-2]
  - wr[n+4+Rsize]
  - raddr[n+3+Rsize:n+4]
  - wsel[n+3:n+2]
  - aop[n+1:n]
  - imm[n-1:0]
- States: IDLE, FETCH, EXEC, HALT.
- Reset (async, nReset=0): state=IDLE, pc=0. All outputs take effect immediately, mid-operation included: w=0, Raddr=0, Wdata=0, alu_op=0, halted=0, pm_addr=0.
- pm_addr = pc at all times (combinational from the pc register).
- IDLE: start=1 -> FETCH; otherwise stay.
- FETCH: one cycle (ROM latency) -> EXEC unconditionally.
- EXEC: outputs are decoded from pm_data; outside EXEC, w=0 and alu_op/Raddr/Wdata hold 0.
  - Raddr=raddr, alu_op=aop.
  - Wdata: wsel 00=imm, 01=alu_res, 10=in_port, 11=imm.
  - w = wr & ~stall.
  - stall=1: remain in EXEC, pc unchanged, no write, z ignored.
  - stall=0: pc update per seq, then go to FETCH (or HALT).
    - seq 00 (next): pc <= pc+1, wrapping modulo 2^PCW (max -> 0).
    - seq 01 (jump): pc <= imm[PCW-1:0].
    - seq 10 (bz): pc <= z ? imm[PCW-1:0] : pc+1; z is sampled in this cycle.
    - seq 11 (halt): pc unchanged, -> HALT. The word's write (if wr=1) still occurs.
- HALT: halted=1. start=1 -> pc <= 0, -> FETCH, halted drops next cycle.
- Throughput: one control word per 2 cycles (FETCH+EXEC), excluding stalls.
- Word at address A first drives outputs in the cycle after FETCH with pc=A.
- start is ignored in FETCH/EXEC.

Decomposition:
- Package nisc_pkg:
  - typedef enum state_t {IDLE, FETCH, EXEC, HALT}
  - seq codes SEQ_NEXT/SEQ_JMP/SEQ_BZ/SEQ_HALT
  - wsel codes WSEL_IMM/WSEL_ALU/WSEL_IN
  - field-position functions parameterised on n, Rsize
- Optional sub-module: nisc_cw_decode (combinational field split plus Wdata mux). The FSM and pc live in nisc_seq.

Test Plan:
- Reset: nReset=0 mid-EXEC with wr=1 word -> w=0, pc=0, state IDLE in the same cycle. After release with start=0 for 5 cycles -> pm_addr stays 0, w never rises.
- Straight line: ROM[0]={00,1,0,00,00,0x5A}, ROM[1]={00,1,1,10,00,0}, in_port=0x33, start pulse -> reg0 written 0x5A at cycle 3, reg1 written 0x33 at cycle 5, pc=2.
- Branch: ROM[2]=bz imm=0x10. With z=1 -> next pm_addr=0x10. Rerun with z=0 -> pm_addr=3.
- Stall: stall=1 for 3 cycles in EXEC on a wr=1 word with wsel=01, alu_res=0x7F -> w=0 during stall. Single write of 0x7F on the first non-stalled cycle; pc advances once.
- Wrap/jump: ROM[0xFF]=next -> pc wraps to 0x00. ROM[0]=jump imm=0xFF with PCW=8 -> pm_addr=0xFF.
- Halt/restart: halt word with wr=1, imm=0x01 -> write occurs, halted=1 next cycle, pc frozen. start=1 -> pc=0, FETCH, halted=0.

Source files
------------

// File: rtl/nisc_pkg.sv
// Shared types, field codes and control-word field positions for the picoNISC sequencer.
package nisc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

  // Sequencing field: how the pc moves once the current word retires.
  typedef enum logic [1:0] {
    SEQ_NEXT = 2'b00,
    SEQ_JMP  = 2'b01,
    SEQ_BZ   = 2'b10,
    SEQ_HALT = 2'b11
  } seq_e;

  // Write-data source select; code 2'b11 falls back to the immediate.
  localparam logic [1:0] WSEL_IMM = 2'b00;
  localparam logic [1:0] WSEL_ALU = 2'b01;
  localparam logic [1:0] WSEL_IN  = 2'b10;

  // Control word layout, MSB first: seq | wr | raddr | wsel | aop | imm.
  function automatic int cw_width(input int n, input int rsize);
    return n + 7 + rsize;
  endfunction

  function automatic int seq_lsb(input int n, input int rsize);
    return n + 5 + rsize;
  endfunction

  function automatic int wr_bit(input int n, input int rsize);
    return n + 4 + rsize;
  endfunction

  function automatic int raddr_lsb(input int n);
    return n + 4;
  endfunction

  function automatic int wsel_lsb(input int n);
    return n + 2;
  endfunction

  function automatic int aop_lsb(input int n);
    return n;
  endfunction

endpackage

// File: rtl/nisc_cw_decode.sv
// Splits a horizontal control word into its fields and selects the register-file write data.
module nisc_cw_decode
  import nisc_pkg::*;
#(
  parameter int n     = 8,
  parameter int Rsize = 1,
  parameter int CWW   = n + 7 + Rsize
) (
  input  logic [CWW-1:0]   cw_i,
  input  logic [n-1:0]     alu_res_i,
  input  logic [n-1:0]     in_port_i,
  output seq_e             seq_o,
  output logic             wr_o,
  output logic [Rsize-1:0] raddr_o,
  output logic [1:0]       aop_o,
  output logic [n-1:0]     imm_o,
  output logic [n-1:0]     wdata_o
);

  localparam int SEQ_LSB   = seq_lsb(n, Rsize);
  localparam int WR_BIT    = wr_bit(n, Rsize);
  localparam int RADDR_LSB = raddr_lsb(n);
  localparam int WSEL_LSB  = wsel_lsb(n);
  localparam int AOP_LSB   = aop_lsb(n);

  logic [1:0] wsel;

  assign seq_o   = seq_e'(cw_i[SEQ_LSB +: 2]);
  assign wr_o    = cw_i[WR_BIT];
  assign raddr_o = cw_i[RADDR_LSB +: Rsize];
  assign wsel    = cw_i[WSEL_LSB +: 2];
  assign aop_o   = cw_i[AOP_LSB +: 2];
  assign imm_o   = cw_i[n-1:0];

  // Write-data mux: immediate, ALU result or input port.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    wdata_o = imm_o;
    case (wsel)
      WSEL_ALU: wdata_o = alu_res_i;
      WSEL_IN:  wdata_o = in_port_i;
      default:  wdata_o = imm_o;
    endcase
  end

endmodule

// File: rtl/nisc_seq.sv
// picoNISC control-word sequencer: fetches words from a synchronous ROM, drives the
// register file and ALU op while executing, and steps the pc (next / jump / bz / halt).
// The pc is loaded from the low PCW bits of the immediate, so PCW must not exceed n.
module nisc_seq
  import nisc_pkg::*;
#(
  parameter int n     = 8,
  parameter int Rsize = 1,
  parameter int PCW   = 8,
  parameter int CWW   = n + 7 + Rsize
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic             start,
  input  logic             stall,
  output logic [PCW-1:0]   pm_addr,
  input  logic [CWW-1:0]   pm_data,
  input  logic             z,
  input  logic [n-1:0]     alu_res,
  input  logic [n-1:0]     in_port,
  output logic             w,
  output logic [Rsize-1:0] Raddr,
  output logic [n-1:0]     Wdata,
  output logic [1:0]       alu_op,
  output logic             halted,
  output logic [PCW-1:0]   pc
);

  state_t           state_q, state_d;
  logic [PCW-1:0]   pc_q, pc_d;

  seq_e             dec_seq;
  logic             dec_wr;
  logic [Rsize-1:0] dec_raddr;
  logic [1:0]       dec_aop;
  logic [n-1:0]     dec_imm;
  logic [n-1:0]     dec_wdata;

  logic [PCW-1:0]   pc_inc;
  logic [PCW-1:0]   pc_imm;

  nisc_cw_decode #(
    .n     (n),
    .Rsize (Rsize),
    .CWW   (CWW)
  ) u_decode (
    .cw_i      (pm_data),
    .alu_res_i (alu_res),
    .in_port_i (in_port),
    .seq_o     (dec_seq),
    .wr_o      (dec_wr),
    .raddr_o   (dec_raddr),
    .aop_o     (dec_aop),
    .imm_o     (dec_imm),
    .wdata_o   (dec_wdata)
  );

  // Sequential increment wraps naturally at PCW bits.
  assign pc_inc  = pc_q + PCW'(1);
  assign pc_imm  = dec_imm[PCW-1:0];

  // ROM address follows the pc register directly, so reset forces it to 0 at once.
  assign pm_addr = pc_q;
  assign pc      = pc_q;
  assign halted  = (state_q == HALT);

  // State and pc registers.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      pc_q    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state, next pc and register-file/ALU controls; controls are only live in EXEC.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    w       = 1'b0;
    Raddr   = '0;
    Wdata   = '0;
    alu_op  = '0;

    case (state_q)
      IDLE: begin
        if (start) state_d = FETCH;
      end

      // One cycle for the synchronous ROM to present the word at pc.
      FETCH: begin
        state_d = EXEC;
      end

      EXEC: begin
        Raddr  = dec_raddr;
        alu_op = dec_aop;
        Wdata  = dec_wdata;
        w      = dec_wr & ~stall;
        // A stalled word holds everything, including the z sample for bz.
        if (!stall) begin
          state_d = FETCH;
          case (dec_seq)
            SEQ_NEXT: pc_d = pc_inc;
            SEQ_JMP:  pc_d = pc_imm;
            SEQ_BZ:   pc_d = z ? pc_imm : pc_inc;
            SEQ_HALT: state_d = HALT;
            default:  pc_d = pc_inc;
          endcase
        end
      end

      HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = FETCH;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_nisc_seq.sv
// Self-checking bench for nisc_seq: an instruction-level reference model predicts each
// register-file write and the next pc; a monitor pops predicted writes whenever w is seen.
module tb_nisc_seq;

  logic        clk;
  logic        nReset;
  logic        start;
  logic        stall;
  logic [7:0]  pm_addr;
  logic [15:0] pm_data;
  logic        z;
  logic [7:0]  alu_res;
  logic [7:0]  in_port;
  logic        w;
  logic [0:0]  Raddr;
  logic [7:0]  Wdata;
  logic [1:0]  alu_op;
  logic        halted;
  logic [7:0]  pc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       raddr;
    logic [7:0] wdata;
    logic [7:0] pc;
    logic [1:0] aop;
  } wr_t;

  wr_t        exp_q[$];
  logic [15:0] rom [256];
  logic [7:0]  mpc;
  logic        m_halted;

  nisc_seq #(
    .n     (8),
    .Rsize (1),
    .PCW   (8),
    .CWW   (16)
  ) dut (
    .clk     (clk),
    .nReset  (nReset),
    .start   (start),
    .stall   (stall),
    .pm_addr (pm_addr),
    .pm_data (pm_data),
    .z       (z),
    .alu_res (alu_res),
    .in_port (in_port),
    .w       (w),
    .Raddr   (Raddr),
    .Wdata   (Wdata),
    .alu_op  (alu_op),
    .halted  (halted),
    .pc      (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read program ROM: data for pm_addr appears one cycle later.
  always @(posedge clk) pm_data <= rom[pm_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every observed write must match the oldest predicted write.
  always @(negedge clk) begin
    wr_t e;
    if (nReset && w) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got w=1 Raddr=%0h Wdata=%0h pc=%0h expected no write at %0t",
                 Raddr, Wdata, pc, $time);
      end else begin
        e = exp_q.pop_front();
        check("wr_raddr", 32'(Raddr),  32'(e.raddr));
        check("wr_wdata", 32'(Wdata),  32'(e.wdata));
        check("wr_pc",    32'(pc),     32'(e.pc));
        check("wr_aop",   32'(alu_op), 32'(e.aop));
      end
    end
  end

  // Execute one word at mpc. Entered and left just after a clock edge; on entry the DUT is in FETCH.
  task automatic step(input int stalls, input logic zv, input logic [7:0] av, input logic [7:0] iv);
    logic [15:0] cw;
    logic [1:0]  sq;
    logic [7:0]  imm;
    logic [7:0]  exp_wdata;
    logic [7:0]  npc;
    @(posedge clk); #1;
    for (int i = 0; i < stalls; i++) begin
      stall   = 1'b1;
      z       = 1'($urandom);
      alu_res = 8'($urandom);
      in_port = 8'($urandom);
      @(posedge clk); #1;
    end
    stall   = 1'b0;
    z       = zv;
    alu_res = av;
    in_port = iv;
    cw  = rom[mpc];
    sq  = cw[15:14];
    imm = cw[7:0];
    case (cw[11:10])
      2'b01:   exp_wdata = av;
      2'b10:   exp_wdata = iv;
      default: exp_wdata = imm;
    endcase
    if (cw[13]) exp_q.push_back('{cw[12], exp_wdata, mpc, cw[9:8]});
    case (sq)
      2'b00:   npc = mpc + 8'd1;
      2'b01:   npc = imm;
      2'b10:   npc = zv ? imm : mpc + 8'd1;
      default: npc = mpc;
    endcase
    @(posedge clk); #1;
    check("next_pm_addr", 32'(pm_addr), 32'(npc));
    check("halted",       32'(halted),  32'(sq == 2'b11));
    mpc      = npc;
    m_halted = (sq == 2'b11);
  endtask

  // From HALT: confirm the pc is frozen, then restart at address 0.
  task automatic restart();
    repeat (2) begin
      @(posedge clk); #1;
      check("halt_pc_frozen", 32'(pc),     32'(mpc));
      check("halt_held",      32'(halted), 32'd1);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("restart_pm_addr", 32'(pm_addr), 32'd0);
    check("restart_halted",  32'(halted),  32'd0);
    mpc      = 8'd0;
    m_halted = 1'b0;
  endtask

  // Hold reset off, leave start low for 5 cycles and confirm nothing moves.
  task automatic idle_after_reset();
    @(posedge clk); #1;
    nReset = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("idle_pm_addr", 32'(pm_addr), 32'd0);
      check("idle_halted",  32'(halted),  32'd0);
    end
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    mpc      = 8'd0;
    m_halted = 1'b0;
  endtask

  initial begin
    nReset  = 1'b0;
    start   = 1'b0;
    stall   = 1'b0;
    z       = 1'b0;
    alu_res = 8'h00;
    in_port = 8'h00;
    mpc     = 8'h00;
    m_halted = 1'b0;
    for (int a = 0; a < 256; a++) rom[a] = 16'h0000;

    // Directed program: seq | wr | raddr | wsel | aop | imm
    rom[8'h00] = {2'b00, 1'b1, 1'b0, 2'b00, 2'b00, 8'h5A};
    rom[8'h01] = {2'b00, 1'b1, 1'b1, 2'b10, 2'b00, 8'h00};
    rom[8'h02] = {2'b10, 1'b0, 1'b0, 2'b00, 2'b01, 8'h10};
    rom[8'h03] = {2'b00, 1'b1, 1'b0, 2'b01, 2'b10, 8'h00};
    rom[8'h04] = {2'b01, 1'b0, 1'b0, 2'b00, 2'b11, 8'hFF};
    rom[8'h10] = {2'b11, 1'b1, 1'b0, 2'b00, 2'b00, 8'h01};
    rom[8'hFF] = {2'b00, 1'b1, 1'b1, 2'b11, 2'b01, 8'hC3};

    #3;
    check("rst_w",       32'(w),       32'd0);
    check("rst_raddr",   32'(Raddr),   32'd0);
    check("rst_wdata",   32'(Wdata),   32'd0);
    check("rst_alu_op",  32'(alu_op),  32'd0);
    check("rst_halted",  32'(halted),  32'd0);
    check("rst_pm_addr", 32'(pm_addr), 32'd0);

    idle_after_reset();

    // Straight line, then bz taken into the halt word.
    step(0, 1'b0, 8'h00, 8'h33);
    step(0, 1'b0, 8'h00, 8'h33);
    check("pc_after_two", 32'(pc), 32'h02);
    step(0, 1'b1, 8'h00, 8'h00);
    step(0, 1'b0, 8'h00, 8'h00);
    restart();

    // bz not taken, stalled ALU write, jump to 0xFF, wrap to 0.
    step(0, 1'b0, 8'h11, 8'h22);
    step(0, 1'b0, 8'h11, 8'h44);
    step(0, 1'b0, 8'h00, 8'h00);
    step(3, 1'b0, 8'h7F, 8'h00);
    step(0, 1'b1, 8'h00, 8'h00);
    step(0, 1'b0, 8'h00, 8'h00);

    // Reset mid-EXEC on a writing word: controls drop in the same cycle.
    @(posedge clk); #1;
    check("exec_w_before_reset", 32'(w), 32'd1);
    nReset = 1'b0;
    #1;
    check("midrst_w",       32'(w),       32'd0);
    check("midrst_pc",      32'(pc),      32'd0);
    check("midrst_pm_addr", 32'(pm_addr), 32'd0);
    check("midrst_wdata",   32'(Wdata),   32'd0);
    check("midrst_raddr",   32'(Raddr),   32'd0);
    check("midrst_alu_op",  32'(alu_op),  32'd0);
    check("midrst_halted",  32'(halted),  32'd0);
    idle_after_reset();

    // Random program: DUT is in FETCH at pc 0.
    for (int a = 0; a < 256; a++) begin
      int r;
      logic [1:0] s;
      r = int'($urandom_range(0, 99));
      s = (r < 6) ? 2'b11 : (r < 20) ? 2'b01 : (r < 40) ? 2'b10 : 2'b00;
      rom[a] = {s, 14'($urandom)};
    end
    for (int k = 0; k < 200; k++) begin
      int ns;
      ns = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      step(ns, 1'($urandom), 8'($urandom), 8'($urandom));
      if (m_halted) restart();
    end

    @(posedge clk); #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
